// File: rtl/regfile_pkg.sv
// Shared widths and the read-port result bundle
// for the integer register file with busy scoreboard.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            busy;
    } regfile_read_t;

endpackage

// File: rtl/scoreboard_bits.sv
// Per-register busy bits: flush beats reserve, and a reserve
// beats a write-back clear to the same index.
module scoreboard_bits
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  write_enable,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic                  reserve_en,
    input  logic [REG_ADDR_W-1:0] reserve_reg,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  busy_any
);

    logic [NUM_REGS-1:0] busy_next;

    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (write_enable && write_reg != ZERO_REG)
                busy_next[write_reg] = 1'b0;
            // the newer instruction owns the register
            if (reserve_en && reserve_reg != ZERO_REG)
                busy_next[reserve_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

    assign busy_any = |busy;

endmodule

// File: rtl/register_file_scoreboard.sv
// Two-read, one-write register file with same-cycle write bypass
// and a busy scoreboard shared between decode and write-back.
module register_file_scoreboard
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  reserve_en,
    input  logic [REG_ADDR_W-1:0] reserve_reg,
    input  logic                  write_enable,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic [XLEN-1:0]       write_data,
    input  logic                  flush,
    output logic                  write_ack,
    output logic                  busy_any
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    regfile_read_t       rd1;
    regfile_read_t       rd2;

    scoreboard_bits u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .reserve_en   (reserve_en),
        .reserve_reg  (reserve_reg),
        .busy         (busy),
        .busy_any     (busy_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            write_ack <= 1'b0;
        end else begin
            write_ack <= write_enable;
            if (write_enable && write_reg != ZERO_REG)
                regs[write_reg] <= write_data;
        end
    end

    // Held reset must not leak the bypassed write value.
    function automatic regfile_read_t read_port(
        input logic                  live,
        input logic                  we,
        input logic [REG_ADDR_W-1:0] wreg,
        input logic [XLEN-1:0]       wdata,
        input logic [REG_ADDR_W-1:0] addr,
        input logic [XLEN-1:0]       stored,
        input logic                  busy_bit
    );
        regfile_read_t r;
        r.data = '0;
        r.busy = 1'b0;
        if (live && addr != ZERO_REG) begin
            if (we && wreg == addr) begin
                r.data = wdata;
            end else begin
                r.data = stored;
                r.busy = busy_bit;
            end
        end
        return r;
    endfunction

    assign rd1 = read_port(reset, write_enable, write_reg, write_data,
                           rs1_addr, regs[rs1_addr], busy[rs1_addr]);
    assign rd2 = read_port(reset, write_enable, write_reg, write_data,
                           rs2_addr, regs[rs2_addr], busy[rs2_addr]);

    assign rs1_data = rd1.data;
    assign rs1_busy = rd1.busy;
    assign rs2_data = rd2.data;
    assign rs2_busy = rd2.busy;

endmodule
